// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads 16-bit words from a stallable
// instruction memory and drives the IF/ID register feeding decode.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt, pc_inc;
  logic [15:0] instr_nxt, pc_plus2_nxt;
  logic        valid_nxt, err_nxt;
  logic        fire, is_halt;

  // Memory handshake: a word transfers on any cycle where imem_req and
  // imem_rdy are both high; imem_data and imem_err are only meaningful then.
  assign pc_inc    = pc + 16'd2;
  assign imem_addr = pc;
  assign imem_req  = ~rst & (state == FETCH) & ~stall & ~redirect;
  assign fire      = imem_req & imem_rdy;
  assign is_halt   = (imem_data[15:11] == 5'b00000);
  assign halted    = (state == HALTED);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    pc_plus2_nxt = pc_plus2;
    valid_nxt    = valid;
    err_nxt      = err | (fire & imem_err);

    if (redirect) begin
      // Targets are halfword aligned; an odd target is flagged, not trapped.
      pc_nxt    = {redirect_pc[15:1], 1'b0};
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
      state_nxt = FETCH;
      if (redirect_pc[0]) err_nxt = 1'b1;
    end else if (stall) begin
      // Everything holds; any memory data this cycle is dropped.
    end else if (state == HALTED) begin
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
    end else if (fire) begin
      instr_nxt    = imem_data;
      pc_plus2_nxt = pc_inc;
      valid_nxt    = 1'b1;
      if (is_halt) state_nxt = HALTED;
      else         pc_nxt    = pc_inc;
    end else begin
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
      pc_plus2 <= 16'h0000;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr    <= instr_nxt;
      pc_plus2 <= pc_plus2_nxt;
      valid    <= valid_nxt;
      err      <= err_nxt;
    end
  end

endmodule
